// File: rtl/mont_arbiter.sv
// Round-robin arbiter that shares one Montgomery multiplier between NUM_REQ requesters.
// One request is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// A multiplier that never finishes is abandoned after TIMEOUT WAIT cycles,
// which sets the sticky error flag.
module mont_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned TIMEOUT = 300
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    input  logic [NUM_REQ-1:0]         i_rsp_ready,
    output logic [WIDTH-1:0]           o_rsp_data,
    output logic                       o_mm_start,
    output logic [WIDTH-1:0]           o_mm_a,
    output logic [WIDTH-1:0]           o_mm_b,
    input  logic [WIDTH-1:0]           i_mm_result,
    input  logic                       i_mm_finished,
    output logic                       o_busy,
    output logic                       o_error
);

    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  tmo_q, tmo_d;
    logic             err_q, err_d;

    logic             gnt_found;
    logic [IdW-1:0]   gnt_id;
    logic [IdW-1:0]   srch_idx;
    logic [IdW-1:0]   id_inc;
    logic [CntW-1:0]  tmo_inc;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        srch_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            srch_idx = IdW'((32'(ptr_q) + i) % NUM_REQ);
            if (!gnt_found && i_req_valid[srch_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = srch_idx;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == IdW'(k)) begin
                gnt_a = i_req_a[k*WIDTH +: WIDTH];
                gnt_b = i_req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    assign id_inc  = (id_q == IdW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    assign tmo_inc = tmo_q + 1'b1;

    // Next-state logic for the request FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    id_d    = gnt_id;
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A finish on the last allowed cycle still wins over the timeout.
                if (i_mm_finished) begin
                    res_d   = i_mm_result;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == CntW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        ptr_d   = id_inc;
                        state_d = StIdle;
                    end
                end
            end
            StResp: begin
                if (i_rsp_ready[id_q]) begin
                    ptr_d   = id_inc;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs; ready is gated by reset since it is combinational from inputs.
    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        if (i_rst_n && (state_q == StIdle) && gnt_found) begin
            o_req_ready[gnt_id] = 1'b1;
        end
        if (state_q == StResp) begin
            o_rsp_valid[id_q] = 1'b1;
        end
    end

    assign o_rsp_data = res_q;
    assign o_mm_start = (state_q == StIssue);
    assign o_mm_a     = a_q;
    assign o_mm_b     = b_q;
    assign o_busy     = (state_q != StIdle);
    assign o_error    = err_q;

    // Structural invariants of the handshake outputs.
    a_ready_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready));
    a_rsp_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_rsp_valid));
    a_ready_idle_only : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_req_ready != '0) |-> !o_busy);

endmodule

// File: doc/mont_arbiter.md
MONT_ARBITER -- requirements
Module: mont_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter: WIDTH, default 256, operand/result width.
REQ-003 Parameter: TIMEOUT, default 300, maximum cycles allowed from mm start to mm finished.
REQ-004 The block SHALL use one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-005 Ports (name direction width meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- i_req_a  in  NUM_REQ*WIDTH  operand A, slice k for requester k
- i_req_b  in  NUM_REQ*WIDTH  operand B, slice k
- o_rsp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero
- i_rsp_ready  in  NUM_REQ  per-requester result accept
- o_rsp_data  out  WIDTH  shared result bus
- o_mm_start  out  1  one-cycle start pulse to the Montgomery multiplier
- o_mm_a  out  WIDTH  operand A to multiplier
- o_mm_b  out  WIDTH  operand B to multiplier
- i_mm_result  in  WIDTH  multiplier result
- i_mm_finished  in  1  multiplier done pulse
- o_busy  out  1  high in any state except IDLE
- o_error  out  1  sticky timeout flag

Function
REQ-006 FSM states: IDLE, ISSUE, WAIT, RESP; transitions only as listed below.
REQ-007 IDLE: grant = first k with i_req_valid[k]=1, searching k = ptr, ptr+1, ..., wrapping modulo NUM_REQ.
REQ-008 IDLE with a grant: o_req_ready[grant]=1 combinationally in the same cycle; the handshake completes that cycle.
REQ-009 On that handshake the block SHALL latch A, B and the grant id, then go to ISSUE.
REQ-010 IDLE with no valid requests: o_req_ready=0, state holds.
REQ-011 o_req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-012 ISSUE lasts exactly one cycle: o_mm_start=1, then go to WAIT.
REQ-013 o_mm_a and o_mm_b SHALL carry the latched operands, stable from ISSUE until the next handshake.
REQ-014 WAIT: on i_mm_finished=1, capture i_mm_result into the result register and go to RESP.
REQ-015 WAIT timeout counter: cleared on entering WAIT, incremented each WAIT cycle.
REQ-016 If the counter reaches TIMEOUT without finished:
- set o_error=1 (sticky until reset);
- return to IDLE with no response issued;
- advance ptr to id+1.
REQ-017 RESP: o_rsp_valid[id]=1 and o_rsp_data=result, both held until i_rsp_ready[id]=1.
REQ-018 In RESP, on i_rsp_ready[id]=1: ptr = (id+1) mod NUM_REQ, go to IDLE; no new request is accepted in that cycle.
REQ-019 i_rsp_ready bits other than id, and i_mm_finished outside WAIT, SHALL be ignored.
REQ-020 A requester deasserting i_req_valid before its handshake SHALL lose no state; the search is re-evaluated every IDLE cycle.
REQ-021 Minimum request-to-response latency = 2 + multiplier latency cycles:
- handshake in cycle T;
- start in T+1;
- rsp_valid in the cycle after finished.
REQ-022 Throughput: at most one request is in flight; back-to-back requests need one IDLE cycle between RESP and the next handshake.

Reset
REQ-023 While i_rst_n=0, all of the following SHALL be 0 and state SHALL be IDLE:
- outputs: o_req_ready, o_rsp_valid, o_rsp_data, o_mm_start, o_mm_a, o_mm_b, o_busy, o_error;
- internal: ptr, timeout counter, latched operands, latched id.
REQ-024 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL discard the in-flight request with no response.
REQ-025 First grant after reset SHALL search from requester 0.

Verification
REQ-026 Single request: req0 valid, A=3, B=5; model multiplier returns 0x1234 after 257 cycles. Required:
- o_mm_start pulses once with A=3, B=5;
- o_rsp_valid[0] with data 0x1234;
- o_busy low after ready.
REQ-027 All four requesters valid from reset. Required:
- grants in order 0,1,2,3,0;
- no requester granted twice while another is waiting.
REQ-028 Wrap-around: only req3 and req0 valid after serving req2 (ptr=3). Required: req3 granted first, then req0.
REQ-029 Response backpressure: i_rsp_ready[1] held low 10 cycles. Required:
- o_rsp_valid[1] and data stable for those 10 cycles;
- no new o_req_ready during that time.
REQ-030 Timeout: model never asserts finished, TIMEOUT=300. Required:
- o_error=1 after 300 WAIT cycles;
- return to IDLE; next request still served.
REQ-031 Reset mid-WAIT. Required:
- outputs 0 immediately (asynchronous);
- after release, a new request on req2 is served normally with ptr search from 0.
